// File: rtl/axa_pkg.sv
// rtl/axa_pkg.sv - shared widths, operand source codes and count-width helper
package axa_pkg;

  localparam int WORD_W     = 16;
  localparam int UNDO_DEPTH = 16;

  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_I4   = 2'd1,
    SRC_ADDR = 2'd2,
    SRC_UNDO = 2'd3
  } src_type_e;

  // Bits needed to hold a count from 0 up to depth inclusive.
  function automatic int clog2_count(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/undo_lifo_if.sv
// rtl/undo_lifo_if.sv - push/pop bus between the pipeline and the undo stack
interface undo_lifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  import axa_pkg::*;

  localparam int CNT_W = clog2_count(DEPTH);

  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [WIDTH-1:0] top;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             dropped;
  logic             underflow;

  modport master (
    output push, push_data, pop,
    input  pop_data, pop_valid, top, count, empty, full, dropped, underflow
  );

  modport slave (
    input  push, push_data, pop,
    output pop_data, pop_valid, top, count, empty, full, dropped, underflow
  );

endinterface

// File: rtl/undo_lifo_ptr.sv
// rtl/undo_lifo_ptr.sv - wrap-around top-of-stack pointer and saturating entry counter
module undo_lifo_ptr import axa_pkg::*; #(
  parameter  int DEPTH = UNDO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = clog2_count(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [PTR_W-1:0] o_tos,
  output logic [PTR_W-1:0] o_tos_up,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_tos;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_tos_up;
  logic [PTR_W-1:0] w_tos_dn;

  // Explicit compare-and-wrap so non-power-of-two depths wrap at DEPTH, not 2**PTR_W.
  always_comb begin
    w_tos_up = (r_tos == LAST_SLOT) ? '0 : r_tos + PTR_W'(1);
    w_tos_dn = (r_tos == '0) ? LAST_SLOT : r_tos - PTR_W'(1);
  end

  // Pointer moves on every push; the count saturates at DEPTH so a full push overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_tos   <= LAST_SLOT;
      r_count <= '0;
    end else if (i_inc) begin
      r_tos <= w_tos_up;
      if (r_count != FULL_CNT) r_count <= r_count + CNT_W'(1);
    end else if (i_dec && (r_count != '0)) begin
      r_tos   <= w_tos_dn;
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_tos    = r_tos;
  assign o_tos_up = w_tos_up;
  assign o_count  = r_count;
  assign o_full   = (r_count == FULL_CNT);
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/undo_lifo.sv
// rtl/undo_lifo.sv - circular undo stack keeping the newest DEPTH values; optional clear via UNDO_LIFO_CLEAR_EN
module undo_lifo import axa_pkg::*; #(
  parameter  int WIDTH = WORD_W,
  parameter  int DEPTH = UNDO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = clog2_count(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
`ifdef UNDO_LIFO_CLEAR_EN
  input  logic        clear,
`endif
  undo_lifo_if.slave  bus
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_pop_data;
  logic             r_pop_valid;
  logic             r_dropped;
  logic             r_underflow;

  logic             w_clear;
  logic             w_push_only;
  logic             w_pop_only;
  logic             w_both;
  logic [PTR_W-1:0] w_tos;
  logic [PTR_W-1:0] w_tos_up;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;

`ifdef UNDO_LIFO_CLEAR_EN
  assign w_clear = clear;
`else
  assign w_clear = 1'b0;
`endif

  // Classify the request; clear suppresses every push/pop in its cycle.
  always_comb begin
    w_push_only = bus.push && !bus.pop && !w_clear;
    w_pop_only  = bus.pop && !bus.push && !w_clear;
    w_both      = bus.push && bus.pop && !w_clear;
  end

  undo_lifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_inc    (w_push_only),
    .i_dec    (w_pop_only),
    .o_tos    (w_tos),
    .o_tos_up (w_tos_up),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Storage write: a push lands one slot above top; replace-top overwrites top in place.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_push_only) begin
        r_mem[w_tos_up] <= bus.push_data;
      end else if (w_both && !w_empty) begin
        r_mem[w_tos] <= bus.push_data;
      end
    end
  end

  // Registered pop result and single-cycle status pulses; pop_data holds when nothing is popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_dropped   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      r_dropped   <= 1'b0;
      r_underflow <= 1'b0;
      if (w_both) begin
        r_pop_valid <= 1'b1;
        r_pop_data  <= w_empty ? bus.push_data : r_mem[w_tos];
      end else if (w_pop_only) begin
        if (w_empty) begin
          r_underflow <= 1'b1;
        end else begin
          r_pop_valid <= 1'b1;
          r_pop_data  <= r_mem[w_tos];
        end
      end else if (w_push_only) begin
        r_dropped <= w_full;
      end
    end
  end

  assign bus.pop_data  = r_pop_data;
  assign bus.pop_valid = r_pop_valid;
  assign bus.dropped   = r_dropped;
  assign bus.underflow = r_underflow;
  assign bus.count     = w_count;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.top       = w_empty ? '0 : r_mem[w_tos];

endmodule

// File: tb/tb_undo_lifo.sv
// tb/tb_undo_lifo.sv - directed checks of undo_lifo at depths 16, 4 and 5; clear port under UNDO_LIFO_CLEAR_EN
module tb_undo_lifo;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef UNDO_LIFO_CLEAR_EN
  logic clear = 1'b0;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  undo_lifo_if #(.WIDTH(16), .DEPTH(16)) b16 ();
  undo_lifo_if #(.WIDTH(16), .DEPTH(4))  b4 ();
  undo_lifo_if #(.WIDTH(16), .DEPTH(5))  b5 ();

  undo_lifo #(.WIDTH(16), .DEPTH(16)) dut16 (
    .clk(clk), .reset(reset),
`ifdef UNDO_LIFO_CLEAR_EN
    .clear(clear),
`endif
    .bus(b16)
  );
  undo_lifo #(.WIDTH(16), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset),
`ifdef UNDO_LIFO_CLEAR_EN
    .clear(clear),
`endif
    .bus(b4)
  );
  undo_lifo #(.WIDTH(16), .DEPTH(5)) dut5 (
    .clk(clk), .reset(reset),
`ifdef UNDO_LIFO_CLEAR_EN
    .clear(clear),
`endif
    .bus(b5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b16.push = 0; b16.pop = 0; b16.push_data = '0;
    b4.push = 0;  b4.pop = 0;  b4.push_data = '0;
    b5.push = 0;  b5.pop = 0;  b5.push_data = '0;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1;
    step(); step();
    reset = 0;
    checks++; if (b16.count !== 0) begin errors++; $display("FAIL reset_count got %0d exp 0", b16.count); end
    checks++; if (b16.empty !== 1'b1 || b16.full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp 1 0", b16.empty, b16.full); end
    checks++; if (b16.top !== 16'h0) begin errors++; $display("FAIL reset_top got %h exp 0000", b16.top); end
    checks++; if (b16.pop_valid !== 0 || b16.dropped !== 0 || b16.underflow !== 0 || b16.pop_data !== 16'h0) begin
      errors++; $display("FAIL reset_pulses got pv=%b dr=%b uf=%b pd=%h exp 0 0 0 0000", b16.pop_valid, b16.dropped, b16.underflow, b16.pop_data); end
    checks++; if (b4.count !== 0 || b5.count !== 0) begin errors++; $display("FAIL reset_small_counts got %0d %0d exp 0 0", b4.count, b5.count); end
  endtask

  task automatic test_lifo_order();
    logic [15:0] vals [3];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      b16.push = 1; b16.push_data = vals[i];
      step();
    end
    b16.push = 0;
    checks++; if (b16.count !== 3) begin errors++; $display("FAIL lifo_count3 got %0d exp 3", b16.count); end
    checks++; if (b16.top !== 16'h3333) begin errors++; $display("FAIL lifo_top got %h exp 3333", b16.top); end
    b16.pop = 1;
    for (int i = 2; i >= 0; i--) begin
      step();
      checks++; if (b16.pop_valid !== 1'b1 || b16.pop_data !== vals[i]) begin
        errors++; $display("FAIL lifo_pop%0d got pv=%b pd=%h exp 1 %h", i, b16.pop_valid, b16.pop_data, vals[i]); end
      checks++; if (b16.count !== i) begin errors++; $display("FAIL lifo_count_after_pop got %0d exp %0d", b16.count, i); end
    end
    b16.pop = 0;
    checks++; if (b16.empty !== 1'b1) begin errors++; $display("FAIL lifo_empty got %b exp 1", b16.empty); end
    step();
    checks++; if (b16.pop_valid !== 1'b0 || b16.pop_data !== 16'h1111) begin
      errors++; $display("FAIL lifo_pv_drop got pv=%b pd=%h exp 0 1111", b16.pop_valid, b16.pop_data); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) begin
      b4.push = 1; b4.push_data = 16'(i);
      step();
      checks++; if (b4.dropped !== (i >= 5)) begin errors++; $display("FAIL ovf_dropped_push%0d got %b exp %b", i, b4.dropped, (i >= 5)); end
    end
    b4.push = 0;
    checks++; if (b4.count !== 4 || b4.full !== 1'b1) begin errors++; $display("FAIL ovf_full got count=%0d full=%b exp 4 1", b4.count, b4.full); end
    checks++; if (b4.top !== 16'd6) begin errors++; $display("FAIL ovf_top got %0d exp 6", b4.top); end
    step();
    checks++; if (b4.dropped !== 1'b0) begin errors++; $display("FAIL ovf_dropped_clear got %b exp 0", b4.dropped); end
    b4.pop = 1;
    for (int i = 6; i >= 3; i--) begin
      step();
      checks++; if (b4.pop_valid !== 1'b1 || b4.pop_data !== 16'(i)) begin
        errors++; $display("FAIL ovf_pop got pv=%b pd=%0d exp 1 %0d", b4.pop_valid, b4.pop_data, i); end
    end
    step();
    checks++; if (b4.underflow !== 1'b1 || b4.pop_valid !== 1'b0 || b4.pop_data !== 16'd3) begin
      errors++; $display("FAIL ovf_underflow got uf=%b pv=%b pd=%0d exp 1 0 3", b4.underflow, b4.pop_valid, b4.pop_data); end
    checks++; if (b4.count !== 0) begin errors++; $display("FAIL ovf_count_floor got %0d exp 0", b4.count); end
    b4.pop = 0;
    step();
    checks++; if (b4.underflow !== 1'b0) begin errors++; $display("FAIL ovf_underflow_pulse got %b exp 0", b4.underflow); end
  endtask

  task automatic test_replace();
    b16.push = 1; b16.push_data = 16'hAAAA;
    step();
    b16.push_data = 16'hBBBB; b16.pop = 1;
    step();
    checks++; if (b16.pop_valid !== 1'b1 || b16.pop_data !== 16'hAAAA) begin
      errors++; $display("FAIL repl_pop got pv=%b pd=%h exp 1 aaaa", b16.pop_valid, b16.pop_data); end
    checks++; if (b16.top !== 16'hBBBB || b16.count !== 1 || b16.dropped !== 1'b0) begin
      errors++; $display("FAIL repl_state got top=%h count=%0d dr=%b exp bbbb 1 0", b16.top, b16.count, b16.dropped); end
    b16.push = 0;
    step();
    checks++; if (b16.pop_data !== 16'hBBBB || b16.count !== 0) begin
      errors++; $display("FAIL repl_drain got pd=%h count=%0d exp bbbb 0", b16.pop_data, b16.count); end
    b16.push = 1; b16.push_data = 16'hC0DE;
    step();
    b16.push = 0; b16.pop = 0;
    checks++; if (b16.pop_valid !== 1'b1 || b16.pop_data !== 16'hC0DE || b16.underflow !== 1'b0) begin
      errors++; $display("FAIL bypass_pop got pv=%b pd=%h uf=%b exp 1 c0de 0", b16.pop_valid, b16.pop_data, b16.underflow); end
    checks++; if (b16.count !== 0 || b16.empty !== 1'b1 || b16.top !== 16'h0) begin
      errors++; $display("FAIL bypass_state got count=%0d empty=%b top=%h exp 0 1 0000", b16.count, b16.empty, b16.top); end
    step();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) begin
      b5.push = 1; b5.push_data = 16'(i);
      step();
    end
    b5.push = 0;
    checks++; if (b5.count !== 5 || b5.full !== 1'b1 || b5.top !== 16'd11) begin
      errors++; $display("FAIL wrap_full got count=%0d full=%b top=%0d exp 5 1 11", b5.count, b5.full, b5.top); end
    b5.pop = 1;
    for (int i = 11; i >= 7; i--) begin
      step();
      checks++; if (b5.pop_valid !== 1'b1 || b5.pop_data !== 16'(i)) begin
        errors++; $display("FAIL wrap_pop got pv=%b pd=%0d exp 1 %0d", b5.pop_valid, b5.pop_data, i); end
    end
    b5.pop = 0;
    checks++; if (b5.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", b5.empty); end
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      b16.push = 1; b16.push_data = 16'h0100 + 16'(i);
      step();
    end
    b16.push = 0;
    checks++; if (b16.count !== 3) begin errors++; $display("FAIL rmid_pre_count got %0d exp 3", b16.count); end
    reset = 1; b16.pop = 1;
    step();
    reset = 0; b16.pop = 0;
    checks++; if (b16.pop_valid !== 1'b0 || b16.count !== 0 || b16.top !== 16'h0) begin
      errors++; $display("FAIL rmid_state got pv=%b count=%0d top=%h exp 0 0 0000", b16.pop_valid, b16.count, b16.top); end
    b16.pop = 1;
    step();
    b16.pop = 0;
    checks++; if (b16.underflow !== 1'b1 || b16.pop_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_gone got uf=%b pv=%b exp 1 0", b16.underflow, b16.pop_valid); end
    step();
  endtask

`ifdef UNDO_LIFO_CLEAR_EN
  task automatic test_clear();
    b16.push = 1; b16.push_data = 16'h0011; step();
    b16.push_data = 16'h0022; step();
    clear = 1; b16.push_data = 16'h5555;
    step();
    clear = 0; b16.push = 0;
    checks++; if (b16.count !== 0 || b16.top !== 16'h0) begin
      errors++; $display("FAIL clear_state got count=%0d top=%h exp 0 0000", b16.count, b16.top); end
    checks++; if (b16.pop_valid !== 1'b0 || b16.dropped !== 1'b0) begin
      errors++; $display("FAIL clear_pulses got pv=%b dr=%b exp 0 0", b16.pop_valid, b16.dropped); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_lifo_order();
    test_overflow();
    test_replace();
    test_wrap();
    test_reset_mid();
`ifdef UNDO_LIFO_CLEAR_EN
    test_clear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
